// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths, NOP encoding, loader FSM states
// and the base addresses where the standard programs are placed.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 10;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam int unsigned PROG_FACT = 0;
    localparam int unsigned PROG_FIB  = 10;
    localparam int unsigned PROG_TEST = 21;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_e;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Load and fetch port bundle of the loadable instruction memory.
// The master side is the host/fetch stage, the slave side is the memory.
interface instr_mem_loadable_if
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W-1:0] load_len;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic              busy;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] instrucao;
    logic              fetch_err;

    modport master (
        output load_start, load_base, load_len, load_valid, load_data,
        output fetch_req, fetch_addr,
        input  load_ready, load_done, load_err, busy,
        input  fetch_valid, instrucao, fetch_err
    );

    modport slave (
        input  load_start, load_base, load_len, load_valid, load_data,
        input  fetch_req, fetch_addr,
        output load_ready, load_done, load_err, busy,
        output fetch_valid, instrucao, fetch_err
    );

endinterface

// File: rtl/imem_ram.sv
// Single-port instruction array: synchronous write, registered read.
// Contents are never reset so a loaded program survives a core reset.
module imem_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = 7
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: valid/ready program load port plus a
// one-cycle-latency fetch port with an out-of-range flag.
module instr_mem_loadable
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DEPTH    = 128,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input logic                 clock,
    input logic                 reset_n,
    instr_mem_loadable_if.slave bus_io
);
    localparam int unsigned     AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    ld_state_e         state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              load_err_q, load_err_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W:0]   load_end;
    logic              fetch_acc, fetch_in_range;
    logic              is_load;
    logic [DATA_W-1:0] instr_out;

    // Extra bit keeps base+len from wrapping into an apparently valid range.
    assign load_end       = {1'b0, bus_io.load_base} + {1'b0, bus_io.load_len};
    assign is_load        = (state_q == LD_LOAD);
    assign fetch_acc      = bus_io.fetch_req && !is_load;
    assign fetch_in_range = ({1'b0, bus_io.fetch_addr} < DepthW);
    assign instr_out      = fetch_valid_q ? (fetch_err_q ? NOP_WORD : ram_rdata) : instr_q;

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        cnt_d         = cnt_q;
        load_err_d    = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = bus_io.fetch_addr[AW-1:0];
        fetch_valid_d = fetch_acc;
        fetch_err_d   = fetch_acc && !fetch_in_range;
        ram_re        = fetch_acc && fetch_in_range;
        instr_d       = instr_out;

        unique case (state_q)
            LD_IDLE: begin
                if (bus_io.load_start) begin
                    if (load_end > DepthW) begin
                        load_err_d = 1'b1;
                    end else if (bus_io.load_len == '0) begin
                        state_d = LD_DONE;
                    end else begin
                        wptr_d  = bus_io.load_base[AW-1:0];
                        cnt_d   = bus_io.load_len;
                        state_d = LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                // Fetch is blocked here, so the single RAM port belongs to the loader.
                ram_addr = wptr_q;
                if (bus_io.load_valid) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    cnt_d  = cnt_q - ADDR_W'(1);
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = LD_DONE;
                    end
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= LD_IDLE;
            wptr_q        <= '0;
            cnt_q         <= '0;
            load_err_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            cnt_q         <= cnt_d;
            load_err_q    <= load_err_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            instr_q       <= instr_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (bus_io.load_data),
        .rdata_o (ram_rdata)
    );

    assign bus_io.load_ready  = is_load;
    assign bus_io.busy        = is_load;
    assign bus_io.load_done   = (state_q == LD_DONE);
    assign bus_io.load_err    = load_err_q;
    assign bus_io.fetch_valid = fetch_valid_q;
    assign bus_io.fetch_err   = fetch_err_q;
    assign bus_io.instrucao   = instr_out;

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised instruction memory for the MIPS datapath. Replaces the fixed, self-initialising program ROM.
- Host/testbench writes programs (factorial, fibonacci, tests) at run time through a valid/ready load port into any base address.
- The fetch port returns instructions with a registered one-cycle latency, plus a range-error flag.
- Sits between the PC/fetch stage and the instruction register.

Parameters:
- DATA_W, 32, instruction word width in bits
- ADDR_W, 10, address width of fetch and load ports
- DEPTH, 128, number of implemented words (DEPTH <= 2**ADDR_W)
- NOP_WORD, 32'h0000_0000, word returned on an out-of-range fetch

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- load_start  in  1  one-cycle request to begin a program load
- load_base  in  ADDR_W  first word address of the load, sampled with load_start
- load_len  in  ADDR_W  number of words to load, sampled with load_start
- load_valid  in  1  load_data holds a word
- load_data  in  DATA_W  instruction word to write
- load_ready  out  1  block accepts load_data this cycle
- load_done  out  1  one-cycle pulse: load finished
- load_err  out  1  one-cycle pulse: load request rejected
- busy  out  1  load in progress
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_valid  out  1  instrucao/fetch_err valid this cycle
- instrucao  out  DATA_W  fetched instruction
- fetch_err  out  1  fetched address was >= DEPTH

Behaviour:
- Reset: clock edge with reset_n=0 forces FSM=IDLE and all of the following to 0: load_ready, load_done, load_err, busy, fetch_valid, fetch_err, instrucao. Memory array is NOT cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE: on load_start, check range.
  - base+len > DEPTH (computed at ADDR_W+1 bits, no wrap): pulse load_err next cycle and stay IDLE.
  - len=0: go to DONE.
  - otherwise: latch wptr=base and remaining count cnt=len, then go to LOAD.
- LOAD:
  - busy=1 and load_ready=1.
  - A word transfers when load_valid & load_ready: RAM[wptr]<=load_data, wptr+1, cnt-1.
  - When the transfer with cnt=1 occurs, go to DONE.
  - load_valid low stalls the load indefinitely with no timeout.
  - load_start during LOAD is ignored.
- DONE: load_done=1 for exactly one cycle, busy=0, then IDLE. A load_start seen in DONE is ignored.
- load_ready is low in IDLE and DONE. Words presented outside LOAD are dropped.
- Fetch handshake:
  - A fetch is accepted when fetch_req=1 and busy=0.
  - One cycle later fetch_valid=1 and instrucao=RAM[fetch_addr]. If fetch_addr >= DEPTH, instrucao=NOP_WORD and fetch_err=1 instead.
  - Back-to-back fetches are allowed: throughput is 1 per cycle.
  - fetch_req while busy=1 is not accepted. fetch_valid=0 the next cycle; the requester must hold and retry.
- When fetch_valid=0, instrucao holds its last value and fetch_err=0.
- Read-after-write: a word written in cycle N is returned by a fetch accepted in cycle N+1 or later. Same-cycle write/fetch cannot occur because fetch is blocked while busy.
- Reset mid-load aborts to IDLE. Words already written are retained. No load_done is produced.
- Address arithmetic is unsigned. wptr never exceeds DEPTH-1, guaranteed by the start check.

Decomposition:
- Shared package mips_pkg:
  - DATA_W/ADDR_W defaults
  - NOP_WORD
  - FSM state enum (LD_IDLE, LD_LOAD, LD_DONE)
  - program base constants (PROG_FACT=0, PROG_FIB=10, PROG_TEST=21)
- One sub-module, imem_ram: a single-port synchronous-write, registered-read array (DEPTH x DATA_W).
- The load FSM, range check and fetch handshake live in the top module.

Test Plan:
- Basic load and fetch: reset; load_start base=0 len=3 with words 0xABC00000, 0x88000000, 0x8C010001 streamed with no gaps → load_done pulses the cycle after the 3rd transfer. Fetches of 0, 1, 2 return those words one cycle after each request, fetch_valid=1, fetch_err=0.
- Stalled load and blocked fetch: load base=10 len=2 with load_valid low for 5 cycles mid-load → busy stays 1 and no load_done. fetch_req=1 addr=10 during the load gives fetch_valid=0. After done, fetch of 10 returns the 1st word.
- Range rejection: base=120 len=9 with DEPTH=128 → load_err pulses, busy stays 0, RAM[120..127] unchanged. Next, base=120 len=8 succeeds with load_done.
- Zero length and out-of-range fetch: len=0 → load_done one cycle later, no writes. fetch_addr=200 → fetch_valid=1, fetch_err=1, instrucao=0x00000000.
- Reset mid-load: load base=0 len=4, assert reset_n=0 after 2 words → FSM IDLE and all outputs 0, no load_done. Fetch 0 and 1 return the written words; fetch 2 returns the prior contents.
- Back-to-back fetch: fetches of addrs 0, 1, 2, 3 in consecutive cycles → 4 consecutive fetch_valid cycles with matching data in order.
